// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The optional access checker is enabled by defining DMEM_ARB_CHECK_EN.
package dmem_arb_pkg;

    // Transfer sizes in bytes
    localparam int SZ_B = 1;
    localparam int SZ_H = 2;
    localparam int SZ_W = 4;
    localparam int SZ_D = 8;

    // One request as presented on the memory port
    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  size;
        logic [63:0] data;
        logic        we;
    } mem_req_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // A request is faulty when misaligned for its size or when it runs past the end of memory.
    // The end address is computed one bit wider so a wrap near 2^64 cannot hide an overrun.
    function automatic logic is_faulty(input logic [63:0] addr,
                                       input logic [3:0]  size,
                                       input logic [63:0] mem_bytes);
        logic [63:0] align_mask;
        logic [64:0] end_addr;
        align_mask = {60'd0, size - 4'd1};
        end_addr   = {1'b0, addr} + {61'd0, size};
        return ((addr & align_mask) != 64'd0) || (end_addr > {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// One-entry load-response register with valid/ready handshake and flush.
// Holds data, tag and error flag stable while the consumer stalls.
module dmem_rsp_slot
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_fire,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              load_err,
    input  logic              flush,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    rsp_state_e        state_reg, state_next;
    logic [DATA_W-1:0] data_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic              err_reg;

    // Slot occupancy register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= RSP_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Occupancy transitions; flush wins over everything, a fire refills a draining slot
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = RSP_EMPTY;
        end else if (load_fire) begin
            state_next = RSP_FULL;
        end else if (state_reg == RSP_FULL && rsp_ready) begin
            state_next = RSP_EMPTY;
        end
    end

    // Payload capture; only a firing load overwrites, so a stalled response stays stable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg <= '0;
            tag_reg  <= '0;
            err_reg  <= 1'b0;
        end else if (load_fire) begin
            data_reg <= load_data;
            tag_reg  <= load_tag;
            err_reg  <= load_err;
        end
    end

    assign rsp_valid = (state_reg == RSP_FULL);
    assign rsp_data  = data_reg;
    assign rsp_tag   = tag_reg;
    assign rsp_err   = err_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port datamem between the LSU load pipe and the
// committed-store drain. Loads have priority; a starvation counter forces a store through
// after STARVE_MAX consecutive denials. Define DMEM_ARB_CHECK_EN to enable the
// alignment/bounds checker that suppresses faulty accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4,
    parameter int MEM_BYTES  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_size,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [3:0]        st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    logic [SC_W-1:0] starve_reg, starve_next;
    logic            slot_free;
    logic            ld_eligible;
    logic            st_win;
    logic            ld_win;
    logic            ld_fault;
    logic            st_fault;
    mem_req_t        mem_req;

    // Access checker: flags misaligned or out-of-range requests
`ifdef DMEM_ARB_CHECK_EN
    always_comb begin
        ld_fault = is_faulty(64'(ld_addr), ld_size, 64'(MEM_BYTES));
        st_fault = is_faulty(64'(st_addr), st_size, 64'(MEM_BYTES));
    end
`else
    assign ld_fault = 1'b0;
    assign st_fault = 1'b0;
`endif

    // Grant: loads first unless the store has waited long enough; nothing granted in reset
    always_comb begin
        slot_free   = !rsp_valid || rsp_ready;
        ld_eligible = reset_n && ld_valid && slot_free && !flush;
        st_win      = reset_n && st_valid && (!ld_eligible || starve_reg == SC_MAX);
        ld_win      = ld_eligible && !st_win;
    end

    assign ld_ready = ld_win;
    assign st_ready = st_win;
    assign st_err   = st_win && st_fault;

    // Starvation count: clears when the store wins or is absent, saturates at the limit
    always_comb begin
        starve_next = starve_reg;
        if (!st_valid || st_win) begin
            starve_next = '0;
        end else if (starve_reg != SC_MAX) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    // Memory port mux: idle drives a harmless 8-byte read-shaped request with enables low
    always_comb begin
        mem_req      = '{addr: 64'd0, size: 4'(SZ_D), data: 64'd0, we: 1'b0};
        mem_read_en  = 1'b0;
        if (st_win) begin
            mem_req.addr = 64'(st_addr);
            mem_req.size = st_size;
            mem_req.data = 64'(st_data);
            mem_req.we   = 1'b1;
        end else if (ld_win) begin
            mem_req.addr = 64'(ld_addr);
            mem_req.size = ld_size;
            mem_read_en  = !ld_fault;
        end
    end

    assign mem_write_en   = mem_req.we && !st_fault;
    assign mem_address    = mem_req.addr[ADDR_W-1:0];
    assign mem_xfer_size  = mem_req.size;
    assign mem_write_data = mem_req.data[DATA_W-1:0];

    dmem_rsp_slot #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_rsp_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_fire (ld_win),
        .load_data (ld_fault ? '0 : mem_read_data),
        .load_tag  (ld_tag),
        .load_err  (ld_fault),
        .flush     (flush),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

endmodule
